// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo: push side (in/we/full)
// and first-word fall-through pop side (out/re/empty).
interface sync_fifo_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in;
   logic             we;
   logic             full;
   logic [WIDTH-1:0] out;
   logic             re;
   logic             empty;

   modport master (
      output in,
      output we,
      output re,
      input  full,
      input  out,
      input  empty
   );

   modport slave (
      input  in,
      input  we,
      input  re,
      output full,
      output out,
      output empty
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and full/empty
// flags derived from a registered occupancy count.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       rst,
   sync_fifo_if.slave fifo
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;

   logic empty_w;
   logic full_w;
   logic wr_ok;
   logic rd_ok;

   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == DEPTH_C);

   // Each request is qualified by the flags as they stood before the edge.
   assign wr_ok = fifo.we & ~full_w;
   assign rd_ok = fifo.re & ~empty_w;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (wr_ok) begin
         wr_ptr_d = AW'(wr_ptr_q + 1'b1);
      end
      if (rd_ok) begin
         rd_ptr_d = AW'(rd_ptr_q + 1'b1);
      end

      unique case ({wr_ok, rd_ok})
         2'b10:   count_d = (AW+1)'(count_q + 1'b1);
         2'b01:   count_d = (AW+1)'(count_q - 1'b1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is never cleared; stale words are hidden by the empty gate on out.
   always_ff @(posedge clk) begin
      if (wr_ok && !rst) begin
         mem_q[wr_ptr_q] <= fifo.in;
      end
   end

   assign fifo.empty = empty_w;
   assign fifo.full  = full_w;
   assign fifo.out   = empty_w ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a vector table for the main walk-through plus
// hand-written wrap-around and mid-operation reset sequences.
module tb_sync_fifo;

   logic clk;
   logic rst;

   sync_fifo_if #(.WIDTH(8)) bus ();

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (8)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .fifo (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       we;
      logic       re;
      logic [7:0] din;
      logic       e_empty;
      logic       e_full;
      logic [7:0] e_out;
   } vec_t;

   vec_t vecs[$];
   int   total;
   int   passed;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic apply(input logic r, input logic w, input logic rd, input logic [7:0] d);
      rst    = r;
      bus.we = w;
      bus.re = rd;
      bus.in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic w, input logic rd, input logic [7:0] d,
                      input logic ee, input logic ef, input logic [7:0] eo);
      vec_t v;
      v.rst = r; v.we = w; v.re = rd; v.din = d;
      v.e_empty = ee; v.e_full = ef; v.e_out = eo;
      vecs.push_back(v);
   endtask

   task automatic check_state(input string tag, input logic ee, input logic ef,
                              input logic [7:0] eo);
      chk({tag, ".empty"}, {7'd0, bus.empty}, {7'd0, ee});
      chk({tag, ".full"},  {7'd0, bus.full},  {7'd0, ef});
      chk({tag, ".out"},   bus.out,           eo);
   endtask

   initial begin
      logic [7:0] q[$];
      int         nxt;
      int         cyc;
      logic       w;
      logic       r;
      logic       wr_ok;
      logic       rd_ok;
      logic [7:0] exp_out;

      total  = 0;
      passed = 0;
      rst    = 1'b1;
      bus.we = 1'b0;
      bus.re = 1'b0;
      bus.in = 8'h00;

      // Reset held three cycles, then three writes.
      add(1, 0, 0, 8'h00, 1, 0, 8'h00);
      add(1, 0, 0, 8'h00, 1, 0, 8'h00);
      add(1, 0, 0, 8'h00, 1, 0, 8'h00);
      add(0, 1, 0, 8'h05, 0, 0, 8'h05);
      add(0, 1, 0, 8'h06, 0, 0, 8'h05);
      add(0, 1, 0, 8'h07, 0, 0, 8'h05);
      // Pop one, then fill to DEPTH.
      add(0, 0, 1, 8'h00, 0, 0, 8'h06);
      add(0, 1, 0, 8'h08, 0, 0, 8'h06);
      add(0, 1, 0, 8'h09, 0, 0, 8'h06);
      add(0, 1, 0, 8'h0A, 0, 0, 8'h06);
      add(0, 1, 0, 8'h0B, 0, 0, 8'h06);
      add(0, 1, 0, 8'h0C, 0, 0, 8'h06);
      add(0, 1, 0, 8'h0D, 0, 1, 8'h06);
      // Write while full is dropped.
      add(0, 1, 0, 8'h0E, 0, 1, 8'h06);
      // Push+pop while full: pop only.
      add(0, 1, 1, 8'h0F, 0, 0, 8'h07);
      // Push+pop mid-range: both happen.
      add(0, 1, 1, 8'h10, 0, 0, 8'h08);
      // Drain: 9,10,11,12,13,16 then empty.
      add(0, 0, 1, 8'h00, 0, 0, 8'h09);
      add(0, 0, 1, 8'h00, 0, 0, 8'h0A);
      add(0, 0, 1, 8'h00, 0, 0, 8'h0B);
      add(0, 0, 1, 8'h00, 0, 0, 8'h0C);
      add(0, 0, 1, 8'h00, 0, 0, 8'h0D);
      add(0, 0, 1, 8'h00, 0, 0, 8'h10);
      add(0, 0, 1, 8'h00, 1, 0, 8'h00);
      // Reads on empty are ignored.
      add(0, 0, 1, 8'h00, 1, 0, 8'h00);
      add(0, 0, 1, 8'h00, 1, 0, 8'h00);
      // Push+pop while empty: write only, then pop it back out.
      add(0, 1, 1, 8'h33, 0, 0, 8'h33);
      add(0, 0, 1, 8'h00, 1, 0, 8'h00);
      // A write after the underflow attempts lands at the head.
      add(0, 1, 0, 8'h44, 0, 0, 8'h44);
      add(0, 0, 1, 8'h00, 1, 0, 8'h00);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].din);
         check_state($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_full, vecs[i].e_out);
      end

      // Wrap: stream 0x00..0x13 with a read on two of every three cycles.
      q.delete();
      nxt = 0;
      cyc = 0;
      while (nxt < 20) begin
         w     = 1'b1;
         r     = (cyc % 3) != 0;
         wr_ok = w && (q.size() < 8);
         rd_ok = r && (q.size() > 0);
         apply(0, w, r, 8'(nxt));
         if (rd_ok) void'(q.pop_front());
         if (wr_ok) begin
            q.push_back(8'(nxt));
            nxt++;
         end
         exp_out = (q.size() > 0) ? q[0] : 8'h00;
         check_state($sformatf("wrap%0d", cyc), q.size() == 0, q.size() == 8, exp_out);
         cyc++;
      end

      // Settle the occupancy at exactly four entries.
      while (q.size() > 4) begin
         apply(0, 0, 1, 8'h00);
         void'(q.pop_front());
         exp_out = (q.size() > 0) ? q[0] : 8'h00;
         check_state($sformatf("trim%0d", q.size()), q.size() == 0, 1'b0, exp_out);
      end
      while (q.size() < 4) begin
         apply(0, 1, 0, 8'(8'h60 + q.size()));
         q.push_back(8'(8'h60 + q.size()));
         check_state($sformatf("fill%0d", q.size()), 1'b0, 1'b0, q[0]);
      end

      // Reset with four entries queued, and a write in the same cycle.
      apply(1, 1, 1, 8'h77);
      check_state("rst_mid", 1'b1, 1'b0, 8'h00);
      apply(0, 0, 0, 8'h00);
      check_state("rst_idle", 1'b1, 1'b0, 8'h00);
      apply(0, 1, 0, 8'hA5);
      check_state("post_rst", 1'b0, 1'b0, 8'hA5);
      apply(0, 0, 1, 8'h00);
      check_state("post_pop", 1'b1, 1'b0, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
